// File: rtl/alu_exec_pipe_pkg.sv
// Shared definitions for the ALU execute stage: operation codes and default datapath width.
// The optional overflow flag is enabled by defining ALU_EXEC_OVF_EN.
package alu_exec_pipe_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_NOTA = 4'b0100,
        ALU_NAND = 4'b0101,
        ALU_NOR  = 4'b0110,
        ALU_ASR  = 4'b1000,
        ALU_LSR  = 4'b1001,
        ALU_LSL  = 4'b1010,
        ALU_ROL  = 4'b1100,
        ALU_ROR  = 4'b1101
    } alu_op_e;

endpackage

// File: rtl/alu_exec_pipe_core.sv
// Combinational ALU: result, zero flag and (when ALU_EXEC_OVF_EN is defined) signed overflow.
// Unlisted op codes produce a zero result with no overflow.
module alu_core
    import alu_exec_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHAMT = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             ovf_o
);

    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD:  res_o = a_i + b_i;
            ALU_SUB:  res_o = a_i - b_i;
            ALU_AND:  res_o = a_i & b_i;
            ALU_OR:   res_o = a_i | b_i;
            ALU_NOTA: res_o = ~a_i;
            ALU_NAND: res_o = ~(a_i & b_i);
            ALU_NOR:  res_o = ~(a_i | b_i);
            ALU_ASR:  res_o = $unsigned($signed(a_i) >>> SHAMT);
            ALU_LSR:  res_o = a_i >> SHAMT;
            ALU_LSL:  res_o = a_i << SHAMT;
            ALU_ROL:  res_o = (a_i << SHAMT) | (a_i >> (WIDTH - SHAMT));
            ALU_ROR:  res_o = (a_i >> SHAMT) | (a_i << (WIDTH - SHAMT));
            default:  res_o = '0;
        endcase
    end

    assign zero_o = (res_o == '0);

`ifdef ALU_EXEC_OVF_EN
    // Overflow is judged purely on sign bits of the operands and the wrapped result.
    always_comb begin
        ovf_o = 1'b0;
        case (op_i)
            ALU_ADD: ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
            ALU_SUB: ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
            default: ovf_o = 1'b0;
        endcase
    end
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/alu_exec_pipe.sv
// Registered ALU execute stage with valid/ready handshake and a 2-entry (main + skid) buffer.
// Define ALU_EXEC_OVF_EN to enable the signed-overflow flag; otherwise Ovf is tied low.
module alu_exec_pipe
    import alu_exec_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHAMT = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] RF_A,
    input  logic [WIDTH-1:0] RF_B,
    input  logic [WIDTH-1:0] Immed,
    input  logic             ALU_Bin_Sel,
    input  logic [3:0]       ALU_func,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Zero,
    output logic             Ovf
);

    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] core_res;
    logic             core_zero;
    logic             core_ovf;

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_res_q,   m_res_d;
    logic             m_zero_q,  m_zero_d;
    logic             m_ovf_q,   m_ovf_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_res_q,   s_res_d;
    logic             s_zero_q,  s_zero_d;
    logic             s_ovf_q,   s_ovf_d;

    logic accept;
    logic m_free;

    assign alu_b = ALU_Bin_Sel ? Immed : RF_B;

    alu_core #(
        .WIDTH (WIDTH),
        .SHAMT (SHAMT)
    ) u_core (
        .a_i    (RF_A),
        .b_i    (alu_b),
        .op_i   (ALU_func),
        .res_o  (core_res),
        .zero_o (core_zero),
        .ovf_o  (core_ovf)
    );

    // Ready depends only on registered skid state, so Out_ready never reaches In_ready combinationally.
    assign accept = In_valid && !s_valid_q;
    assign m_free = !m_valid_q || Out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_res_d   = m_res_q;
        m_zero_d  = m_zero_q;
        m_ovf_d   = m_ovf_q;
        s_valid_d = s_valid_q;
        s_res_d   = s_res_q;
        s_zero_d  = s_zero_q;
        s_ovf_d   = s_ovf_q;
        if (Flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_free) begin
            // Skid contents take priority; accept is impossible while the skid is occupied.
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_res_d   = s_res_q;
                m_zero_d  = s_zero_q;
                m_ovf_d   = s_ovf_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_res_d   = core_res;
                m_zero_d  = core_zero;
                m_ovf_d   = core_ovf;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_res_d   = core_res;
            s_zero_d  = core_zero;
            s_ovf_d   = core_ovf;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_valid_q <= 1'b0;
            m_res_q   <= '0;
            m_zero_q  <= 1'b0;
            m_ovf_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_res_q   <= '0;
            s_zero_q  <= 1'b0;
            s_ovf_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_res_q   <= m_res_d;
            m_zero_q  <= m_zero_d;
            m_ovf_q   <= m_ovf_d;
            s_valid_q <= s_valid_d;
            s_res_q   <= s_res_d;
            s_zero_q  <= s_zero_d;
            s_ovf_q   <= s_ovf_d;
        end
    end

    assign In_ready  = !s_valid_q;
    assign Out_valid = m_valid_q;
    assign ALU_out   = m_res_q;
    assign Zero      = m_zero_q;
    assign Ovf       = m_ovf_q;

endmodule
